pe_noc_packetizer: RTL and testbench

//  - Clocked injection stage between a PE result port and its NoC input port (PE_xxxx_i).
//  - Takes PE results in a type/dest/data form and builds 33-bit NoC packets: {type[32], dest[31:28], src[27:24], data[23:0]}.
//  - Buffers packets in a FIFO and presents them to the NoC through a valid/ready handshake with a registered output stage.

---
 rtl/pe_noc_packetizer.sv | 135 +++++++++++++
 tb/tb_pe_noc_packetizer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pe_noc_packetizer.sv
// pe_noc_packetizer: injection stage between a PE result port and its NoC input.
// Builds 33-bit packets {type, dest, src, data} from PE requests, buffers them
// in a DEPTH-entry FIFO and presents them through a registered valid/ready
// output stage. Requests addressed to this PE are dropped and flagged.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   pe_valid/pe_ready   PE request handshake (pe_ready = FIFO not full)
//   pe_type/dest/data   request fields
//   noc_valid/ready     NoC handshake, noc_packet is the registered payload
//   fifo_count          FIFO occupancy (output register not included)
//   err_loopback        sticky flag for dropped dest==SRC_ADDR requests
//   err_clear           clears err_loopback (a same-cycle set wins)
//   pkt_sent            16-bit NoC handshake counter (NOC_PKT_CNT_EN only)
//
// Build option: define NOC_PKT_CNT_EN to add the pkt_sent port and counter.
module pe_noc_packetizer #(
  parameter logic [3:0]  SRC_ADDR = 4'b0000,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pe_valid,
  output logic             pe_ready,
  input  logic             pe_type,
  input  logic [3:0]       pe_dest,
  input  logic [23:0]      pe_data,
  output logic             noc_valid,
  input  logic             noc_ready,
  output logic [32:0]      noc_packet,
  output logic [CNT_W-1:0] fifo_count,
  output logic             err_loopback,
  input  logic             err_clear
`ifdef NOC_PKT_CNT_EN
  ,
  output logic [15:0]      pkt_sent
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic        ptype;
    logic [3:0]  dest;
    logic [3:0]  src;
    logic [23:0] data;
  } noc_pkt_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  out_state_t       state_q, state_d;
  noc_pkt_t         mem [DEPTH];
  noc_pkt_t         wr_pkt;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             fifo_empty, fifo_full;
  logic             accept, push, pop, loopback;

  // Full/empty come from the occupancy counter, never from pointer compare.
  assign fifo_full  = (count == CNT_W'(DEPTH));
  assign fifo_empty = (count == '0);
  assign pe_ready   = !fifo_full;
  assign fifo_count = count;
  assign noc_valid  = (state_q == OUT_FULL);

  assign accept   = pe_valid && pe_ready;
  assign push     = accept && (pe_dest != SRC_ADDR);
  assign loopback = accept && (pe_dest == SRC_ADDR);

  assign wr_pkt = '{ptype: pe_type, dest: pe_dest, src: SRC_ADDR, data: pe_data};

  // Output stage next-state and pop decision.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      OUT_EMPTY: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = OUT_FULL;
        end
      end
      OUT_FULL: begin
        if (noc_ready) begin
          if (!fifo_empty) pop = 1'b1;
          else             state_d = OUT_EMPTY;
        end
      end
    endcase
  end

  // Control state: FSM, pointers, occupancy, output register, error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= OUT_EMPTY;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      noc_packet   <= '0;
      err_loopback <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr     <= rd_ptr + PTR_W'(1);
        noc_packet <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (loopback)       err_loopback <= 1'b1;
      else if (err_clear) err_loopback <= 1'b0;
    end
  end

  // Storage array; contents are don't-care after reset since pointers restart.
  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr] <= wr_pkt;
  end

`ifdef NOC_PKT_CNT_EN
  // Handshake counter, wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (reset)                       pkt_sent <= '0;
    else if (noc_valid && noc_ready) pkt_sent <= pkt_sent + 16'd1;
  end
`endif

endmodule

// File: tb/tb_pe_noc_packetizer.sv
// Self-checking bench for pe_noc_packetizer (SRC_ADDR=4'hD, DEPTH=4).
// Directed table, hand-written corner sequences and random traffic, all
// checked against a queue-based reference model.
module tb_pe_noc_packetizer;

  localparam logic [3:0]  SRC   = 4'hD;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             pe_valid = 1'b0;
  logic             pe_ready;
  logic             pe_type = 1'b0;
  logic [3:0]       pe_dest = 4'h0;
  logic [23:0]      pe_data = 24'h0;
  logic             noc_valid;
  logic             noc_ready = 1'b0;
  logic [32:0]      noc_packet;
  logic [CNT_W-1:0] fifo_count;
  logic             err_loopback;
  logic             err_clear = 1'b0;
`ifdef NOC_PKT_CNT_EN
  logic [15:0]      pkt_sent;
`endif

  pe_noc_packetizer #(.SRC_ADDR(SRC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .pe_valid(pe_valid), .pe_ready(pe_ready),
    .pe_type(pe_type), .pe_dest(pe_dest), .pe_data(pe_data),
    .noc_valid(noc_valid), .noc_ready(noc_ready), .noc_packet(noc_packet),
    .fifo_count(fifo_count), .err_loopback(err_loopback), .err_clear(err_clear)
`ifdef NOC_PKT_CNT_EN
    , .pkt_sent(pkt_sent)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int dut_hs = 0;

  // Reference model: everything in flight behind the output register is a
  // plain queue; the output register is a valid flag plus a payload.
  logic [32:0] mq[$];
  logic        m_ov   = 1'b0;
  logic [32:0] m_out  = '0;
  logic        m_err  = 1'b0;
  logic [15:0] m_sent = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic t, input logic [3:0] d,
                      input logic [23:0] dat, input logic nr, input logic clr,
                      input logic rs);
    logic acc, hs, pop;
    pe_valid = v; pe_type = t; pe_dest = d; pe_data = dat;
    noc_ready = nr; err_clear = clr; reset = rs;
    @(posedge clk);
    if (!rs && noc_valid && nr) dut_hs++;
    if (rs) begin
      mq.delete(); m_ov = 1'b0; m_out = '0; m_err = 1'b0; m_sent = '0;
    end else begin
      acc = v && (mq.size() != DEPTH);
      hs  = m_ov && nr;
      pop = (mq.size() > 0) && (!m_ov || nr);
      if (hs) m_sent = m_sent + 16'd1;
      if (pop) begin
        m_out = mq.pop_front();
        m_ov  = 1'b1;
      end else if (hs) begin
        m_ov = 1'b0;
      end
      if (acc && d != SRC) mq.push_back({t, d, SRC, dat});
      if (acc && d == SRC) m_err = 1'b1;
      else if (clr)        m_err = 1'b0;
    end
    #1;
    chk("noc_valid", 64'(noc_valid), 64'(m_ov));
    chk("noc_packet", 64'(noc_packet), 64'(m_out));
    chk("fifo_count", 64'(fifo_count), 64'(mq.size()));
    chk("pe_ready", 64'(pe_ready), 64'(mq.size() != DEPTH));
    chk("err_loopback", 64'(err_loopback), 64'(m_err));
`ifdef NOC_PKT_CNT_EN
    chk("pkt_sent", 64'(pkt_sent), 64'(m_sent));
`endif
  endtask

  typedef struct {
    logic        v, t;
    logic [3:0]  d;
    logic [23:0] dat;
    logic        nr, clr, rs;
    logic        ev;
    logic [32:0] epkt;
    logic [2:0]  ecnt;
    logic        eerr, erdy;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int h0;
    // v t d     data        nr clr rs | valid packet         cnt err rdy
    tbl[0] = '{1'b0, 1'b0, 4'h0, 24'h0,      1'b0, 1'b0, 1'b1, 1'b0, 33'h0,          3'd0, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 1'b1, 4'hA, 24'h000155, 1'b0, 1'b0, 1'b0, 1'b0, 33'h0,          3'd1, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 1'b0, 4'h0, 24'h0,      1'b0, 1'b0, 1'b0, 1'b1, 33'h1_AD00_0155, 3'd0, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 4'hD, 24'h00BEEF, 1'b0, 1'b0, 1'b0, 1'b1, 33'h1_AD00_0155, 3'd0, 1'b1, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 4'hD, 24'h000001, 1'b0, 1'b1, 1'b0, 1'b1, 33'h1_AD00_0155, 3'd0, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 4'h0, 24'h0,      1'b0, 1'b1, 1'b0, 1'b1, 33'h1_AD00_0155, 3'd0, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 4'h0, 24'h0,      1'b1, 1'b0, 1'b0, 1'b0, 33'h1_AD00_0155, 3'd0, 1'b0, 1'b1};

    // Basic packet build, latency, loopback drop and err_clear priority.
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].v, tbl[i].t, tbl[i].d, tbl[i].dat, tbl[i].nr, tbl[i].clr, tbl[i].rs);
      chk($sformatf("tbl%0d_valid", i), 64'(noc_valid), 64'(tbl[i].ev));
      chk($sformatf("tbl%0d_packet", i), 64'(noc_packet), 64'(tbl[i].epkt));
      chk($sformatf("tbl%0d_count", i), 64'(fifo_count), 64'(tbl[i].ecnt));
      chk($sformatf("tbl%0d_err", i), 64'(err_loopback), 64'(tbl[i].eerr));
      chk($sformatf("tbl%0d_ready", i), 64'(pe_ready), 64'(tbl[i].erdy));
    end

    // Fill: 6 offers with the NoC stalled, 5 fit, then drain in order.
    step(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) step(1, i[0], 4'h3, 24'(32'h100 + i), 0, 0, 0);
    chk("fill_count", 64'(fifo_count), 64'd4);
    chk("fill_ready", 64'(pe_ready), 64'd0);
    chk("fill_head", 64'(noc_packet), 64'({1'b0, 4'h3, SRC, 24'h000100}));
    h0 = dut_hs;
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 1, 0, 0);
    chk("fill_drained", 64'(dut_hs - h0), 64'd5);
    chk("fill_idle_valid", 64'(noc_valid), 64'd0);

    // Backpressure: payload holds for 10 stalled cycles, then advances.
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 4'h7, 24'hAAAAAA, 0, 0, 0);
    step(1, 1, 4'h8, 24'h555555, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      chk("stall_hold", 64'(noc_packet), 64'({1'b0, 4'h7, SRC, 24'hAAAAAA}));
    end
    step(0, 0, 0, 0, 1, 0, 0);
    chk("stall_next", 64'(noc_packet), 64'({1'b1, 4'h8, SRC, 24'h555555}));
    chk("stall_next_valid", 64'(noc_valid), 64'd1);

    // Streaming at one packet per cycle, with a reset in the middle.
    step(0, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 4'h2, 24'(i), 1, 0, 0);
      if (i > 0) chk("stream_count", 64'(fifo_count), 64'd1);
    end
    step(1, 0, 4'h2, 24'hFF, 1, 0, 1);
    chk("midrst_valid", 64'(noc_valid), 64'd0);
    chk("midrst_count", 64'(fifo_count), 64'd0);
    for (int i = 0; i < 10; i++) step(1, 1, 4'h4, 24'(32'h200 + i), 1, 0, 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] d;
      d = ($urandom_range(0, 4) == 0) ? SRC : 4'($urandom);
      step(1'($urandom_range(0, 2) != 0), 1'($urandom), d, 24'($urandom),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 300) == 0));
    end

`ifdef NOC_PKT_CNT_EN
    // Counter wrap: stream up to FFFE handshakes, then three more.
    step(0, 0, 0, 0, 1, 0, 1);
    while (m_sent != 16'hFFFE) step(1, 0, 4'h1, 24'h0, 1, 0, 0);
    step(1, 0, 4'h1, 24'h0, 1, 0, 0);
    chk("cnt_ffff", 64'(pkt_sent), 64'h0000_FFFF);
    step(1, 0, 4'h1, 24'h0, 1, 0, 0);
    chk("cnt_0000", 64'(pkt_sent), 64'h0000_0000);
    step(1, 0, 4'h1, 24'h0, 1, 0, 0);
    chk("cnt_0001", 64'(pkt_sent), 64'h0000_0001);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
